// File: rtl/moore_pkg.sv
// Shared types and defaults for the Moore sequence detector and its event logger.
// The optional build macro MOORE_LOG_OVERWRITE_EN is consumed by moore_log_fifo.
package moore_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNT_W = 8;

    typedef logic [STATE_W-1:0] state_t;

endpackage : moore_pkg

// File: rtl/moore_log_fifo.sv
// Small FIFO holding detector state codes for the event logger.
// Full-FIFO push policy: drop newest by default; with MOORE_LOG_OVERWRITE_EN
// defined, the oldest entry is overwritten and the read pointer advances.
module moore_log_fifo
    import moore_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned W     = STATE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] count;
    logic             do_pop;
    logic             push_full;
    logic             do_write;
    logic             overwrite;
    logic             grow;

    assign full   = (count == LVL_W'(DEPTH));
    assign empty  = (count == '0);
    assign level  = count;
    assign dout   = empty ? '0 : mem[rd_ptr];

    assign do_pop    = pop & ~empty;
    assign push_full = push & full & ~do_pop;

`ifdef MOORE_LOG_OVERWRITE_EN
    assign overwrite = push_full;
    assign do_write  = push;
`else
    assign overwrite = 1'b0;
    assign do_write  = push & ~push_full;
`endif

    // Occupancy only grows on a real new slot, not on an overwrite.
    assign grow = do_write & ~overwrite;

    // Storage array; no reset needed since dout is gated by empty.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (grow && !do_pop) begin
                count <= count + LVL_W'(1);
            end else if (!grow && do_pop) begin
                count <= count - LVL_W'(1);
            end
        end
    end

endmodule : moore_log_fifo

// File: rtl/moore_event_logger.sv
// Event logger for the Moore sequence detector: counts rising edges of the
// detector output and logs every state change into a valid/ready FIFO.
// Build option MOORE_LOG_OVERWRITE_EN selects overwrite-oldest on a full FIFO.
module moore_event_logger #(
    parameter int unsigned DEPTH   = moore_pkg::DEF_DEPTH,
    parameter int unsigned CNT_W   = moore_pkg::DEF_CNT_W,
    parameter int unsigned STATE_W = moore_pkg::STATE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   det_out,
    input  logic [STATE_W-1:0]     det_state,
    output logic [CNT_W-1:0]       det_cnt,
    output logic [STATE_W-1:0]     log_data,
    output logic                   log_valid,
    input  logic                   log_ready,
    output logic [$clog2(DEPTH):0] log_level,
    output logic                   overflow
);

    logic               prev_out;
    logic [STATE_W-1:0] prev_state;
    logic               rise;
    logic               chg;
    logic               pop;
    logic               lost;
    logic               fifo_full;
    logic               fifo_empty;

    assign rise      = det_out & ~prev_out;
    assign chg       = (det_state != prev_state);
    assign log_valid = ~fifo_empty;
    assign pop       = log_valid & log_ready;
    assign lost      = chg & fifo_full & ~pop;

    moore_log_fifo #(
        .DEPTH (DEPTH),
        .W     (STATE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (chg),
        .din   (det_state),
        .pop   (pop),
        .dout  (log_data),
        .level (log_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Edge history, saturating detection counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_out   <= 1'b0;
            prev_state <= '0;
            det_cnt    <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_out   <= det_out;
            prev_state <= det_state;
            if (rise && (det_cnt != '1)) begin
                det_cnt <= det_cnt + CNT_W'(1);
            end
            if (lost) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule : moore_event_logger

// File: tb/tb_moore_event_logger.sv
// Scoreboard bench for moore_event_logger; honours MOORE_LOG_OVERWRITE_EN.
module tb_moore_event_logger;

    logic       clk = 1'b0;
    logic       rst;
    logic       det_out;
    logic [1:0] det_state;
    logic       log_ready;
    logic [7:0] det_cnt;
    logic [1:0] log_data;
    logic       log_valid;
    logic [2:0] log_level;
    logic       overflow;

    logic [1:0] sat_cnt;
    logic [1:0] sat_data;
    logic       sat_valid;
    logic [2:0] sat_level;
    logic       sat_overflow;

    int checks = 0;
    int errors = 0;

    logic [1:0] q [$];
    logic [1:0] m_prev_state;
    logic       m_prev_out;
    int         m_cnt;
    int         m_cnt_sat;
    logic       m_ovf;

    always #5 clk = ~clk;

    moore_event_logger #(.DEPTH(4), .CNT_W(8), .STATE_W(2)) dut (
        .clk(clk), .rst(rst), .det_out(det_out), .det_state(det_state),
        .det_cnt(det_cnt), .log_data(log_data), .log_valid(log_valid),
        .log_ready(log_ready), .log_level(log_level), .overflow(overflow)
    );

    moore_event_logger #(.DEPTH(4), .CNT_W(2), .STATE_W(2)) dut_sat (
        .clk(clk), .rst(rst), .det_out(det_out), .det_state(det_state),
        .det_cnt(sat_cnt), .log_data(sat_data), .log_valid(sat_valid),
        .log_ready(log_ready), .log_level(sat_level), .overflow(sat_overflow)
    );

    task automatic model_reset();
        q.delete();
        m_prev_state = 2'b00;
        m_prev_out   = 1'b0;
        m_cnt        = 0;
        m_cnt_sat    = 0;
        m_ovf        = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; det_state = 2'b00; det_out = 1'b0; log_ready = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    // One clock of stimulus; scoreboard pops are compared before the edge,
    // level/count/overflow after it.
    task automatic cycle(input logic [1:0] st, input logic o, input logic rdy);
        logic pop;
        @(negedge clk);
        rst = 1'b0; det_state = st; det_out = o; log_ready = rdy;
        pop = rdy && (q.size() > 0);
        if (pop) begin
            checks++;
            if (log_valid !== 1'b1 || log_data !== q[0]) begin
                errors++;
                $display("FAIL pop_data: got valid=%b data=%b, expected valid=1 data=%b",
                         log_valid, log_data, q[0]);
            end
            q.delete(0);
        end
        if (st != m_prev_state) begin
            if (q.size() == 4 && !pop) begin
                m_ovf = 1'b1;
`ifdef MOORE_LOG_OVERWRITE_EN
                q.delete(0);
                q.push_back(st);
`endif
            end else begin
                q.push_back(st);
            end
        end
        if (o && !m_prev_out) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_sat < 3) m_cnt_sat++;
        end
        m_prev_state = st;
        m_prev_out   = o;
        @(posedge clk); #1;
        checks++;
        if (log_level !== 3'(q.size()) || overflow !== m_ovf || det_cnt !== 8'(m_cnt)
            || sat_cnt !== 2'(m_cnt_sat) || log_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL cycle_state: got level=%0d ovf=%b cnt=%0d sat=%0d valid=%b, expected level=%0d ovf=%b cnt=%0d sat=%0d valid=%b",
                     log_level, overflow, det_cnt, sat_cnt, log_valid,
                     q.size(), m_ovf, m_cnt, m_cnt_sat, (q.size() > 0));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; det_state = 2'b11; det_out = 1'b1; log_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (det_cnt !== 8'd0 || log_valid !== 1'b0 || log_level !== 3'd0
                || overflow !== 1'b0 || log_data !== 2'b00) begin
                errors++;
                $display("FAIL reset_values: got cnt=%0d valid=%b level=%0d ovf=%b data=%b, expected all zero",
                         det_cnt, log_valid, log_level, overflow, log_data);
            end
        end
        model_reset();
        cycle(2'b11, 1'b1, 1'b0);
        checks++;
        if (det_cnt !== 8'd1 || log_level !== 3'd1 || log_data !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: got cnt=%0d level=%0d data=%b, expected cnt=1 level=1 data=11",
                     det_cnt, log_level, log_data);
        end
        cycle(2'b11, 1'b1, 1'b1);
    endtask

    task automatic test_ordered_drain();
        apply_reset();
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        checks++;
        if (log_level !== 3'd2 || log_data !== 2'b01) begin
            errors++;
            $display("FAIL drain_fill: got level=%0d data=%b, expected level=2 data=01",
                     log_level, log_data);
        end
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b0, 1'b1);
        checks++;
        if (log_valid !== 1'b0 || log_level !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: got valid=%b level=%0d, expected valid=0 level=0",
                     log_valid, log_level);
        end
    endtask

    task automatic test_level_vs_edge();
        logic pat [8];
        pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(2'b00, pat[i], 1'b0);
        checks++;
        if (det_cnt !== 8'd3) begin
            errors++;
            $display("FAIL level_vs_edge: got cnt=%0d, expected 3", det_cnt);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(2'b00, 1'b1, 1'b0);
            cycle(2'b00, 1'b0, 1'b0);
        end
        cycle(2'b00, 1'b1, 1'b0);
        checks++;
        if (sat_cnt !== 2'd3 || det_cnt !== 8'd6) begin
            errors++;
            $display("FAIL saturation: got sat=%0d cnt=%0d, expected sat=3 cnt=6", sat_cnt, det_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] seq [5];
        logic [1:0] head;
        seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
`ifdef MOORE_LOG_OVERWRITE_EN
        head = 2'b10;
`else
        head = 2'b01;
`endif
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(seq[i], 1'b0, 1'b0);
        checks++;
        if (log_level !== 3'd4 || overflow !== 1'b1 || log_data !== head) begin
            errors++;
            $display("FAIL overflow: got level=%0d ovf=%b head=%b, expected level=4 ovf=1 head=%b",
                     log_level, overflow, log_data, head);
        end
        for (int i = 0; i < 4; i++) cycle(2'b01, 1'b0, 1'b1);
        apply_reset();
        checks++;
        if (overflow !== 1'b0 || log_level !== 3'd0) begin
            errors++;
            $display("FAIL overflow_clear: got ovf=%b level=%0d, expected ovf=0 level=0",
                     overflow, log_level);
        end
    endtask

    task automatic test_full_concurrent_pop();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b11, 2'b00};
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(seq[i], 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b1);
        checks++;
        if (log_level !== 3'd4 || overflow !== 1'b0 || log_data !== 2'b10) begin
            errors++;
            $display("FAIL full_pop: got level=%0d ovf=%b head=%b, expected level=4 ovf=0 head=10",
                     log_level, overflow, log_data);
        end
        for (int i = 0; i < 4; i++) cycle(2'b10, 1'b0, 1'b1);
        checks++;
        if (log_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_drain: got valid=%b ovf=%b, expected valid=0 ovf=0",
                     log_valid, overflow);
        end
    endtask

    initial begin
        rst = 1'b1; det_out = 1'b0; det_state = 2'b00; log_ready = 1'b0;
        model_reset();
        test_reset();
        test_ordered_drain();
        test_level_vs_edge();
        test_saturation();
        test_overflow();
        test_full_concurrent_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_moore_event_logger

// File: doc/moore_event_logger.md
Name: moore_event_logger

Overview:
- Downstream consumer of the 2-bit Moore sequence detector; samples the detector's `out` and `state` every clock.
- Counts detections: rising edges of `out`, saturating.
- Logs each state change into a small FIFO, drained by a valid/ready read port.
- Gives the bench and debug logic a cycle-accurate trace of detector activity.

Parameters:
- DEPTH, 4, log FIFO entries; power of two, >= 2
- CNT_W, 8, width of the detection counter
- STATE_W, 2, width of the detector state code

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- det_out  input  1  detector `out`, same clock domain
- det_state  input  STATE_W  detector `state`, same clock domain
- det_cnt  output  CNT_W  saturating count of det_out rising edges
- log_data  output  STATE_W  state code at FIFO head
- log_valid  output  1  FIFO non-empty, log_data meaningful
- log_ready  input  1  consumer accepts head when log_valid=1
- log_level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky flag: a state change was lost or overwritten

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst is synchronous and active-high; it dominates all other activity in that cycle.
- Reset values:
  - det_cnt=0, log_level=0, log_valid=0, overflow=0.
  - log_data=0, and internal prev_out=0, prev_state=0.
- Edge detection:
  - rise = det_out & ~prev_out.
  - prev_out and prev_state are updated with the current inputs every clock.
- Counter:
  - On rise, det_cnt increments by 1.
  - At 2^CNT_W-1 it holds; no wrap.
  - A det_out level held high for N cycles counts once.
- Push:
  - chg = (det_state != prev_state).
  - When chg=1, det_state is written to the FIFO tail at that edge.
  - First cycle after reset: a non-zero det_state counts as a change from 0.
- Pop:
  - log_valid & log_ready at an edge removes the head.
  - log_ready is ignored when log_valid=0.
- Latency:
  - A pushed entry appears on log_data/log_valid the cycle after the push edge.
  - No empty-FIFO bypass.
- Simultaneous push and pop:
  - Both occur; log_level is unchanged.
  - When full, the pop frees a slot for the push; overflow is not set.
- Full, push, no pop:
  - Default: the new entry is dropped and overflow is set.
- Pointers and ordering:
  - Pointers wrap modulo DEPTH.
  - log_level ranges 0..DEPTH.
  - Entries are strictly FIFO-ordered.
- overflow:
  - Cleared only by rst.
- Reset mid-operation:
  - FIFO contents are discarded, the counter is cleared, and the edge history is cleared.
  - No pop is acknowledged in the reset cycle.
- Combinational dependencies:
  - log_data, log_valid and log_level are registered/pointer-derived.
  - They have no combinational path from det_* inputs.

Optional Feature:
- Macro: MOORE_LOG_OVERWRITE_EN.
- Defined: push into a full FIFO with no pop overwrites the oldest entry.
  - The read pointer advances, so log_data shows the second-oldest entry next cycle.
  - log_level stays DEPTH and overflow is set.
- Undefined: drop-newest behaviour as above.
- The port list is identical in both builds.

Decomposition:
- Package moore_pkg:
  - STATE_W constant.
  - state_t typedef (logic [STATE_W-1:0]).
  - Default DEPTH and CNT_W localparams.
  - Shared with the detector and its bench.
- Sub-module moore_log_fifo:
  - Parameterised DEPTH-entry state_t FIFO with push, pop, level and full/empty outputs.
  - Owns the MOORE_LOG_OVERWRITE_EN logic.
- The top level holds edge/change detection, the saturating counter and the overflow flag.

Test Plan:
- Reset: rst=1 for 2 cycles with det_state=2'b11, det_out=1.
  - During reset: det_cnt=0, log_valid=0, log_level=0, overflow=0.
  - First cycle after release: one push of 11 and one count.
- Ordered drain: log_ready=0, det_state 00→01→10→10.
  - Result: log_level=2, log_data=01.
  - Then log_ready=1: reads 01 then 10, after which log_valid=0, log_level=0.
- Level vs edge: det_out pattern 0,1,1,1,0,1,0,1.
  - Result: det_cnt=3.
- Counter saturation: CNT_W=2, 5 rising edges.
  - Result: det_cnt=3 and held.
- Overflow: DEPTH=4, log_ready=0, states 01,10,11,00,01.
  - Default build: log_level=4, overflow=1, drain yields 01,10,11,00.
  - With MOORE_LOG_OVERWRITE_EN: drain yields 10,11,00,01.
- Full with concurrent pop: FIFO full, log_ready=1, and a state change in the same cycle.
  - Result: log_level stays 4, overflow=0, new entry is last out.
